gbar_core_client: RTL and testbench

- Core-side initiator for the global barrier protocol.
- Collects barrier arrivals from the warps of one core and resolves local (intra-core) barriers on its own.
- For a global barrier, it sends one request per completed local barrier to the cluster-level global barrier unit, then waits for the matching response.
- On completion it releases the waiting warp mask back to the warp scheduler.

---
 rtl/gbar_core_client.sv | 193 +++++++++++++++++++
 tb/tb_gbar_core_client.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gbar_core_client.sv
// gbar_core_client: core-side initiator for the global barrier protocol.
// Collects warp arrivals per barrier id, resolves local barriers directly, and
// for global barriers issues one request to the cluster unit, then releases the
// held warp mask when the matching response arrives.
// Optional feature: define GBAR_PERF_EN to build perf_gbar_wait_cycles, a
// saturating count of cycles with any barrier in REQ or WAIT. Without it the
// output is tied to 0.
// Ports:
//   clk, reset           clock, asynchronous active-high reset
//   bar_*                warp arrival (valid/ready) with id, warp, kind, sizes
//   release_*            one-cycle release pulse with id and warp mask
//   gbar_req_*           request to global unit (valid/ready) with payload
//   gbar_rsp_*           single-cycle response pulse from global unit
//   perf_gbar_wait_cycles  wait-cycle counter (optional)
module gbar_core_client #(
  parameter int unsigned NUM_WARPS    = 4,
  parameter int unsigned NUM_BARRIERS = 4,
  parameter int unsigned NUM_CORES    = 4,
  parameter int unsigned CORE_ID      = 0,
  localparam int unsigned NW_W = (NUM_WARPS    > 1) ? $clog2(NUM_WARPS)    : 1,
  localparam int unsigned NB_W = (NUM_BARRIERS > 1) ? $clog2(NUM_BARRIERS) : 1,
  localparam int unsigned NC_W = (NUM_CORES    > 1) ? $clog2(NUM_CORES)    : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 bar_valid,
  output logic                 bar_ready,
  input  logic [NB_W-1:0]      bar_id,
  input  logic [NW_W-1:0]      bar_warp_id,
  input  logic                 bar_is_global,
  input  logic [NW_W-1:0]      bar_local_size_m1,
  input  logic [NC_W-1:0]      bar_global_size_m1,
  output logic                 release_valid,
  output logic [NB_W-1:0]      release_id,
  output logic [NUM_WARPS-1:0] release_mask,
  output logic                 gbar_req_valid,
  input  logic                 gbar_req_ready,
  output logic [NB_W-1:0]      gbar_req_id,
  output logic [NC_W-1:0]      gbar_req_size_m1,
  output logic [NC_W-1:0]      gbar_req_core_id,
  input  logic                 gbar_rsp_valid,
  input  logic [NB_W-1:0]      gbar_rsp_id,
  output logic [31:0]          perf_gbar_wait_cycles
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_REQ     = 2'd2,
    ST_WAIT    = 2'd3
  } bar_state_t;

  bar_state_t           state     [NUM_BARRIERS];
  logic [NUM_WARPS-1:0] mask      [NUM_BARRIERS];
  logic                 is_global [NUM_BARRIERS];
  logic [NC_W-1:0]      gsize     [NUM_BARRIERS];

  function automatic logic [NW_W:0] popcount(input logic [NUM_WARPS-1:0] m);
    logic [NW_W:0] c;
    c = '0;
    for (int i = 0; i < NUM_WARPS; i++) c = c + (NW_W+1)'(m[i]);
    return c;
  endfunction

  // Arrival decode for the addressed barrier
  logic                 accept;
  logic [NUM_WARPS-1:0] cur_mask;
  logic [NUM_WARPS-1:0] warp_bit;
  logic [NUM_WARPS-1:0] new_mask;
  logic                 dup;
  logic                 first;
  logic                 done;
  logic                 eff_global;

  assign bar_ready = !reset && !gbar_rsp_valid &&
                     (state[bar_id] == ST_IDLE || state[bar_id] == ST_COLLECT);
  assign accept    = bar_valid && bar_ready;
  assign cur_mask  = mask[bar_id];
  assign warp_bit  = NUM_WARPS'(1) << bar_warp_id;
  assign new_mask  = cur_mask | warp_bit;
  assign dup       = |(cur_mask & warp_bit);
  assign first     = (state[bar_id] == ST_IDLE);
  assign done      = (NW_W'(popcount(cur_mask)) == bar_local_size_m1);
  // Kind is latched by the first arrival; later arrivals follow the latched flag
  assign eff_global = first ? bar_is_global : is_global[bar_id];

  // Response targets a barrier actually waiting
  logic rsp_hit;
  assign rsp_hit = gbar_rsp_valid && (state[gbar_rsp_id] == ST_WAIT);

  // Lowest-numbered barrier in REQ, skipping the one being handshaked now
  logic            hs;
  logic            pick_found;
  logic [NB_W-1:0] pick_id;
  assign hs = gbar_req_valid && gbar_req_ready;

  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    for (int i = 0; i < NUM_BARRIERS; i++) begin
      if (!pick_found && state[i] == ST_REQ && !(hs && NB_W'(i) == gbar_req_id)) begin
        pick_found = 1'b1;
        pick_id    = NB_W'(i);
      end
    end
  end

  // Per-barrier FSMs, release port and request register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_BARRIERS; i++) begin
        state[i]     <= ST_IDLE;
        mask[i]      <= '0;
        is_global[i] <= 1'b0;
        gsize[i]     <= '0;
      end
      release_valid    <= 1'b0;
      release_id       <= '0;
      release_mask     <= '0;
      gbar_req_valid   <= 1'b0;
      gbar_req_id      <= '0;
      gbar_req_size_m1 <= '0;
      gbar_req_core_id <= '0;
    end else begin
      release_valid <= 1'b0;
      release_id    <= '0;
      release_mask  <= '0;

      if (accept && !dup) begin
        if (first) begin
          is_global[bar_id] <= bar_is_global;
          gsize[bar_id]     <= bar_global_size_m1;
        end
        if (done) begin
          if (eff_global) begin
            mask[bar_id]  <= new_mask;
            state[bar_id] <= ST_REQ;
          end else begin
            release_valid <= 1'b1;
            release_id    <= bar_id;
            release_mask  <= new_mask;
            mask[bar_id]  <= '0;
            state[bar_id] <= ST_IDLE;
          end
        end else begin
          mask[bar_id]  <= new_mask;
          state[bar_id] <= ST_COLLECT;
        end
      end

      // Arrivals stall during a response cycle, so this never collides above
      if (rsp_hit) begin
        release_valid      <= 1'b1;
        release_id         <= gbar_rsp_id;
        release_mask       <= mask[gbar_rsp_id];
        mask[gbar_rsp_id]  <= '0;
        state[gbar_rsp_id] <= ST_IDLE;
      end

      // Load a new request when the bus is free or just handshaked
      if (hs) state[gbar_req_id] <= ST_WAIT;
      if (!gbar_req_valid || hs) begin
        gbar_req_valid <= pick_found;
        if (pick_found) begin
          gbar_req_id      <= pick_id;
          gbar_req_size_m1 <= gsize[pick_id];
          gbar_req_core_id <= NC_W'(CORE_ID);
        end
      end
    end
  end

`ifdef GBAR_PERF_EN
  logic any_busy;

  always_comb begin
    any_busy = 1'b0;
    for (int i = 0; i < NUM_BARRIERS; i++) begin
      if (state[i] == ST_REQ || state[i] == ST_WAIT) any_busy = 1'b1;
    end
  end

  // Saturating wait-cycle counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) perf_gbar_wait_cycles <= '0;
    else if (any_busy && perf_gbar_wait_cycles != 32'hFFFF_FFFF)
      perf_gbar_wait_cycles <= perf_gbar_wait_cycles + 32'd1;
  end
`else
  assign perf_gbar_wait_cycles = '0;
`endif

endmodule

// File: tb/tb_gbar_core_client.sv
// tb_gbar_core_client: directed and randomized self-checking bench for
// gbar_core_client (4 warps, 4 barriers, 4 cores, CORE_ID = 2).
module tb_gbar_core_client;

  localparam int unsigned CID = 2;

  logic        clk;
  logic        reset;
  logic        bar_valid;
  logic        bar_ready;
  logic [1:0]  bar_id;
  logic [1:0]  bar_warp_id;
  logic        bar_is_global;
  logic [1:0]  bar_local_size_m1;
  logic [1:0]  bar_global_size_m1;
  logic        release_valid;
  logic [1:0]  release_id;
  logic [3:0]  release_mask;
  logic        gbar_req_valid;
  logic        gbar_req_ready;
  logic [1:0]  gbar_req_id;
  logic [1:0]  gbar_req_size_m1;
  logic [1:0]  gbar_req_core_id;
  logic        gbar_rsp_valid;
  logic [1:0]  gbar_rsp_id;
  logic [31:0] perf_gbar_wait_cycles;

  int checks = 0;
  int errors = 0;

  gbar_core_client #(
    .NUM_WARPS(4), .NUM_BARRIERS(4), .NUM_CORES(4), .CORE_ID(CID)
  ) dut (
    .clk(clk), .reset(reset),
    .bar_valid(bar_valid), .bar_ready(bar_ready), .bar_id(bar_id),
    .bar_warp_id(bar_warp_id), .bar_is_global(bar_is_global),
    .bar_local_size_m1(bar_local_size_m1), .bar_global_size_m1(bar_global_size_m1),
    .release_valid(release_valid), .release_id(release_id), .release_mask(release_mask),
    .gbar_req_valid(gbar_req_valid), .gbar_req_ready(gbar_req_ready),
    .gbar_req_id(gbar_req_id), .gbar_req_size_m1(gbar_req_size_m1),
    .gbar_req_core_id(gbar_req_core_id),
    .gbar_rsp_valid(gbar_rsp_valid), .gbar_rsp_id(gbar_rsp_id),
    .perf_gbar_wait_cycles(perf_gbar_wait_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one arrival, wait (bounded) for acceptance; returns just after the accepting edge
  task automatic arrive(input int id, input int w, input bit g, input int lsz, input int gsz);
    int n;
    bar_valid          = 1'b1;
    bar_id             = 2'(id);
    bar_warp_id        = 2'(w);
    bar_is_global      = g;
    bar_local_size_m1  = 2'(lsz);
    bar_global_size_m1 = 2'(gsz);
    n = 0;
    #1;
    while (!bar_ready && n < 50) begin
      step();
      n++;
    end
    chk("arrive_accept", 32'(n < 50), 32'd1);
    step();
    bar_valid = 1'b0;
  endtask

  task automatic pulse_rsp(input int id);
    gbar_rsp_valid = 1'b1;
    gbar_rsp_id    = 2'(id);
    step();
    gbar_rsp_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    #1;
  endtask

  // Reference model state for randomized local barriers
  bit has [4][4];
  int cnt [4];
  int sz  [4];

  initial begin
    logic [3:0] m;
    int b, w, perf_exp, busy;
    bit rel;

    reset = 1'b1; bar_valid = 1'b0; bar_id = '0; bar_warp_id = '0;
    bar_is_global = 1'b0; bar_local_size_m1 = '0; bar_global_size_m1 = '0;
    gbar_req_ready = 1'b0; gbar_rsp_valid = 1'b0; gbar_rsp_id = '0;

    // Reset state
    #3;
    chk("rst_bar_ready", 32'(bar_ready), 32'd0);
    chk("rst_release_valid", 32'(release_valid), 32'd0);
    chk("rst_req_valid", 32'(gbar_req_valid), 32'd0);
    chk("rst_core_id", 32'(gbar_req_core_id), 32'd0);
    chk("rst_perf", perf_gbar_wait_cycles, 32'd0);
    step();
    reset = 1'b0;
    #1;
    chk("post_rst_bar_ready", 32'(bar_ready), 32'd1);

    // Local barrier 0, four warps
    for (int i = 0; i < 4; i++) begin
      arrive(0, i, 1'b0, 3, 0);
      chk("local_rel_valid", 32'(release_valid), (i == 3) ? 32'd1 : 32'd0);
    end
    chk("local_rel_id", 32'(release_id), 32'd0);
    chk("local_rel_mask", 32'(release_mask), 32'hF);
    chk("local_no_req", 32'(gbar_req_valid), 32'd0);
    step();
    chk("local_pulse_end", 32'(release_valid), 32'd0);
    chk("local_no_req2", 32'(gbar_req_valid), 32'd0);

    // Global barrier 2, with duplicate warp 1 in COLLECT
    arrive(2, 1, 1'b1, 1, 3);
    chk("g_first_norel", 32'(release_valid), 32'd0);
    arrive(2, 1, 1'b1, 1, 3);
    step();
    chk("dup_no_req", 32'(gbar_req_valid), 32'd0);
    arrive(2, 3, 1'b1, 1, 3);
    chk("g_complete_norel", 32'(release_valid), 32'd0);
    chk("g_req_not_yet", 32'(gbar_req_valid), 32'd0);
    step();
    chk("g_req_valid", 32'(gbar_req_valid), 32'd1);
    chk("g_req_id", 32'(gbar_req_id), 32'd2);
    chk("g_req_size", 32'(gbar_req_size_m1), 32'd3);
    chk("g_req_core", 32'(gbar_req_core_id), 32'(CID));
    for (int i = 0; i < 3; i++) begin
      step();
      chk("g_hold_valid", 32'(gbar_req_valid), 32'd1);
      chk("g_hold_id", 32'(gbar_req_id), 32'd2);
      chk("g_hold_size", 32'(gbar_req_size_m1), 32'd3);
    end
    gbar_req_ready = 1'b1;
    step();
    gbar_req_ready = 1'b0;
    chk("g_req_drop", 32'(gbar_req_valid), 32'd0);
    // Warp 0 to barrier 2 in WAIT stalls until the release
    bar_valid = 1'b1; bar_id = 2'd2; bar_warp_id = 2'd0; bar_is_global = 1'b1;
    bar_local_size_m1 = 2'd1; bar_global_size_m1 = 2'd3;
    #1;
    chk("wait_stall0", 32'(bar_ready), 32'd0);
    step();
    chk("wait_stall1", 32'(bar_ready), 32'd0);
    gbar_rsp_valid = 1'b1; gbar_rsp_id = 2'd2;
    #1;
    chk("rsp_cycle_stall", 32'(bar_ready), 32'd0);
    step();
    gbar_rsp_valid = 1'b0;
    #1;
    chk("g_rel_valid", 32'(release_valid), 32'd1);
    chk("g_rel_id", 32'(release_id), 32'd2);
    chk("g_rel_mask", 32'(release_mask), 32'hA);
    chk("g_ready_after_rel", 32'(bar_ready), 32'd1);
    bar_valid = 1'b0;
    step();
    chk("g_pulse_end", 32'(release_valid), 32'd0);

    // Arbitration: 0 outstanding, then 3 and 1 queue up; lowest id wins
    do_reset();
    arrive(0, 0, 1'b1, 0, 1);
    step();
    chk("arb_req0", 32'(gbar_req_id), 32'd0);
    arrive(3, 1, 1'b1, 0, 2);
    arrive(1, 2, 1'b1, 0, 3);
    step();
    chk("arb_hold_valid", 32'(gbar_req_valid), 32'd1);
    chk("arb_hold_id", 32'(gbar_req_id), 32'd0);
    gbar_req_ready = 1'b1;
    step();
    chk("arb_b2b_valid1", 32'(gbar_req_valid), 32'd1);
    chk("arb_second_id", 32'(gbar_req_id), 32'd1);
    chk("arb_second_size", 32'(gbar_req_size_m1), 32'd3);
    step();
    chk("arb_b2b_valid2", 32'(gbar_req_valid), 32'd1);
    chk("arb_third_id", 32'(gbar_req_id), 32'd3);
    chk("arb_third_size", 32'(gbar_req_size_m1), 32'd2);
    step();
    gbar_req_ready = 1'b0;
    chk("arb_done", 32'(gbar_req_valid), 32'd0);
    pulse_rsp(2);
    chk("stray_rsp_norel", 32'(release_valid), 32'd0);
    pulse_rsp(3);
    chk("arb_rel3", {28'd0, release_valid, 1'b0, release_id}, {28'd0, 1'b1, 1'b0, 2'd3});
    chk("arb_mask3", 32'(release_mask), 32'h2);
    pulse_rsp(1);
    chk("arb_rel1", {28'd0, release_valid, 1'b0, release_id}, {28'd0, 1'b1, 1'b0, 2'd1});
    chk("arb_mask1", 32'(release_mask), 32'h4);
    pulse_rsp(0);
    chk("arb_rel0", {28'd0, release_valid, 1'b0, release_id}, {28'd0, 1'b1, 1'b0, 2'd0});
    chk("arb_mask0", 32'(release_mask), 32'h1);

    // Reset while barrier 0 waits and barrier 1 is being requested
    arrive(0, 0, 1'b1, 0, 1);
    gbar_req_ready = 1'b1;
    step();
    step();
    gbar_req_ready = 1'b0;
    arrive(1, 1, 1'b1, 0, 1);
    step();
    chk("pre_rst_req", 32'(gbar_req_valid), 32'd1);
    reset = 1'b1;
    #1;
    chk("mid_rst_req_valid", 32'(gbar_req_valid), 32'd0);
    chk("mid_rst_req_id", 32'(gbar_req_id), 32'd0);
    chk("mid_rst_core", 32'(gbar_req_core_id), 32'd0);
    chk("mid_rst_rel", 32'(release_valid), 32'd0);
    chk("mid_rst_ready", 32'(bar_ready), 32'd0);
    step();
    reset = 1'b0;
    #1;
    pulse_rsp(0);
    chk("post_rst_rsp_norel", 32'(release_valid), 32'd0);
    bar_id = 2'd0;
    #1;
    chk("post_rst_idle", 32'(bar_ready), 32'd1);

    // Wait-cycle counter: one global barrier busy for 7 cycles
    do_reset();
    arrive(0, 0, 1'b1, 0, 1);
    gbar_req_ready = 1'b1;
    busy = 0;
    for (int k = 1; k <= 7; k++) begin
      if (k == 7) begin
        gbar_rsp_valid = 1'b1;
        gbar_rsp_id    = 2'd0;
      end
      busy++;
      step();
    end
    gbar_rsp_valid = 1'b0;
    gbar_req_ready = 1'b0;
`ifdef GBAR_PERF_EN
    perf_exp = busy;
`else
    perf_exp = 0;
`endif
    chk("perf_rel", 32'(release_valid), 32'd1);
    chk("perf_count", perf_gbar_wait_cycles, 32'(perf_exp));
    step();
    step();
    chk("perf_stable", perf_gbar_wait_cycles, 32'(perf_exp));

    // Randomized local barriers against a set-based model
    for (int i = 0; i < 4; i++) begin
      cnt[i] = 0;
      for (int j = 0; j < 4; j++) has[i][j] = 1'b0;
    end
    for (int n = 0; n < 160; n++) begin
      b = $urandom_range(0, 3);
      w = $urandom_range(0, 3);
      if (cnt[b] == 0) sz[b] = $urandom_range(0, 3);
      rel = 1'b0;
      m = '0;
      if (!has[b][w]) begin
        has[b][w] = 1'b1;
        cnt[b]++;
        if (cnt[b] == sz[b] + 1) begin
          rel = 1'b1;
          for (int j = 0; j < 4; j++) if (has[b][j]) m[j] = 1'b1;
          cnt[b] = 0;
          for (int j = 0; j < 4; j++) has[b][j] = 1'b0;
        end
      end
      arrive(b, w, 1'b0, sz[b], 0);
      chk("rnd_rel_valid", 32'(release_valid), 32'(rel));
      if (rel) begin
        chk("rnd_rel_id", 32'(release_id), 32'(b));
        chk("rnd_rel_mask", 32'(release_mask), 32'(m));
      end
    end
    chk("rnd_no_req", 32'(gbar_req_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
